lin_class_seq: RTL and testbench
================================

Name: lin_class_seq

Overview:
Frame sequencer for the lin_class linear classifier. On start, it reads the 4096 pixels of a 64x64 image from three channel memories (im1/im2/im3) and streams them into lin_class's free-running pipeline. It tracks in-flight pixels through the read and classifier latencies, writes each weighted sum and pos bit to a result buffer at the matching address, and counts positive pixels. It sits between the image RAMs, lin_class and the result RAM.

Parameters:
N_PIX, 4096, pixels per frame
AW, 12, address width (log2 N_PIX)
DW, 6, pixel channel width
SW, 16, weighted-sum width
RD_LAT, 1, image RAM read latency in cycles (>=1)
CLS_LAT, 4, lin_class input-to-output latency in cycles

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_start  in  1  start frame; sampled in IDLE only
i_pause  in  1  suppress new reads while high; in-flight pixels drain normally
i_abort  in  1  cancel frame, flush in-flight pixels
o_busy  out  1  high from the cycle after an accepted start until the o_done cycle
o_done  out  1  one-cycle pulse after the last result write
o_rd_en  out  1  image RAM read enable
o_rd_addr  out  AW  image RAM read address
i_rd_im1/i_rd_im2/i_rd_im3  in  DW each  image RAM data, valid RD_LAT cycles after o_rd_en
o_cls_im1/o_cls_im2/o_cls_im3  out  DW each  registered pixel to lin_class i_im1..3
i_cls_wgt_sum  in  SW  lin_class o_wgt_sum
i_cls_pos  in  1  lin_class o_pos
o_res_we  out  1  result RAM write enable
o_res_addr  out  AW  result address (equals source pixel address)
o_res_wgt_sum  out  SW  registered weighted sum
o_res_pos  out  1  registered pos bit
o_pos_cnt  out  AW+1  number of pos=1 results in the current or last frame

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: all outputs are 0. The state is IDLE. The delay line is cleared.
- States:
  - IDLE: i_start=1 and i_abort=0 -> ISSUE. On this transition, o_pos_cnt clears to 0 and the read pointer clears to 0.
  - ISSUE: each cycle with i_pause=0 asserts o_rd_en, drives o_rd_addr=pointer, then increments the pointer. After the read at address N_PIX-1 is issued -> DRAIN.
  - DRAIN: no reads. When the delay line is empty and the last write has occurred -> DONE.
  - DONE: o_done=1 for one cycle, then -> IDLE. o_busy=0 in DONE.
- i_start is ignored outside IDLE.
- i_abort in any non-IDLE state -> IDLE on the next edge. The delay line flushes, o_res_we=0 from the next cycle, no o_done pulse, o_pos_cnt holds its partial count.
- i_abort and i_start together in IDLE: abort wins and the block stays in IDLE.
- Pipeline timing for a read issued at cycle t with address A (defaults give a 7-cycle issue-to-write latency, L = RD_LAT+CLS_LAT+2):
  - t+RD_LAT: i_rd_im* is valid.
  - t+RD_LAT+1: o_cls_im* is registered from i_rd_im*.
  - t+RD_LAT+1+CLS_LAT: i_cls_* is sampled.
  - t+L: o_res_we=1, o_res_addr=A, o_res_* registered.
- Bubbles:
  - o_cls_im* = 0 on cycles with no valid pixel.
  - o_res_we = 0 for bubble slots.
  - Pause creates bubbles only; result order and addresses are preserved.
- Tracking: a valid+address delay line of depth L carries each issued read to its result slot. No tracking is needed from the classifier itself.
- o_pos_cnt increments by 1 on each o_res_we cycle with o_res_pos=1. It saturates at N_PIX. It holds after DONE until the next accepted start.
- Pointer wrap: the pointer never wraps within a frame. It reaches N_PIX-1, then stops.
- Reset mid-frame behaves exactly like the reset values above; no partial-state recovery.

Decomposition:
- lin_class_pkg holds:
  - the N_PIX, AW, DW, SW, RD_LAT and CLS_LAT defaults;
  - the derived constant L;
  - the state enum {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module: lin_class_dly, a parameterised depth-L valid+AW shift register with synchronous flush and asynchronous active-high reset.
- The FSM, pointer and counter stay in lin_class_seq.

Test Plan:
- Reset release, then i_start at edge k with defaults:
  - o_rd_en/o_rd_addr=0 at k+1, first o_res_we at k+8 with o_res_addr=0;
  - last read at addr 4095 at k+4096, last write at k+4103, o_done at k+4104;
  - o_busy high k+1..k+4103.
- Model lin_class with the golden weighted-sum table and im1/im2/im3 images -> every o_res_wgt_sum matches golden[addr], o_res_addr strictly increasing 0..4095, o_pos_cnt equals the golden pos count.
- i_pause high for 10 cycles at addresses 100..: no o_rd_en during the pause, 10-cycle gap in o_res_we, no lost or duplicated addresses, o_done delayed by exactly 10 cycles.
- i_abort at read address 2000:
  - state IDLE next cycle;
  - no o_res_we afterwards, no o_done;
  - o_pos_cnt frozen;
  - a new i_start then reruns from addr 0 with o_pos_cnt cleared.
- i_start asserted during ISSUE, and i_start+i_abort together in IDLE -> both ignored (pointer unaffected; stays IDLE).
- i_rst pulse mid-DRAIN -> all outputs 0 asynchronously, no o_done; next i_start runs a full clean frame.

Source files
------------

// File: rtl/lin_class_pkg.sv
// lin_class_pkg: shared sizes, pipeline latencies and sequencer states for lin_class_seq
package lin_class_pkg;
    localparam int N_PIX   = 4096;
    localparam int AW      = 12;
    localparam int DW      = 6;
    localparam int SW      = 16;
    localparam int RD_LAT  = 1;
    localparam int CLS_LAT = 4;
    localparam int L       = RD_LAT + CLS_LAT + 2;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/lin_class_dly.sv
// lin_class_dly: valid+address delay line carrying each issued read to its result slot
module lin_class_dly #(
    parameter int DEPTH = 7,
    parameter int W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [W-1:0]     in_addr,
    output logic [DEPTH-1:0] vld,
    output logic [W-1:0]     out_addr
);
    logic [W-1:0] addr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) addr[i] <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            vld <= {vld[DEPTH-2:0], in_vld};
            addr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) addr[i] <= addr[i-1];
        end
    end

    assign out_addr = addr[DEPTH-1];
endmodule

// File: rtl/lin_class_seq.sv
// lin_class_seq: streams a 64x64 frame from the image RAMs through lin_class into the result RAM
module lin_class_seq
    import lin_class_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_pause,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [DW-1:0] i_rd_im1,
    input  logic [DW-1:0] i_rd_im2,
    input  logic [DW-1:0] i_rd_im3,
    output logic [DW-1:0] o_cls_im1,
    output logic [DW-1:0] o_cls_im2,
    output logic [DW-1:0] o_cls_im3,
    input  logic [SW-1:0] i_cls_wgt_sum,
    input  logic          i_cls_pos,
    output logic          o_res_we,
    output logic [AW-1:0] o_res_addr,
    output logic [SW-1:0] o_res_wgt_sum,
    output logic          o_res_pos,
    output logic [AW:0]   o_pos_cnt
);
    state_t state, state_nx;
    logic [AW-1:0] ptr;
    logic [L-1:0] vld;
    logic start_ok, flush, issue, last_rd, drained, run, run_nx, cls_vld, res_vld;

    assign start_ok = state == IDLE && i_start && !i_abort;
    assign flush    = state != IDLE && i_abort;
    assign issue    = state == ISSUE && !i_pause && !i_abort;
    assign last_rd  = issue && ptr == AW'(N_PIX - 1);
    // only the final write may still be in the line, and nothing is about to enter it
    assign drained  = state == DRAIN && !o_rd_en && vld[L-2:0] == '0;
    assign run      = state == ISSUE || state == DRAIN;
    assign run_nx   = state_nx == ISSUE || state_nx == DRAIN;
    assign cls_vld  = vld[RD_LAT-1] && !flush;
    assign res_vld  = vld[L-2] && !flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = flush ? IDLE : start_ok ? ISSUE : last_rd ? DRAIN :
                   drained ? DONE : state == DONE ? IDLE : state;
    end

    always_comb begin
        o_done = state == DONE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr           <= '0;
            o_busy        <= 1'b0;
            o_rd_en       <= 1'b0;
            o_rd_addr     <= '0;
            o_cls_im1     <= '0;
            o_cls_im2     <= '0;
            o_cls_im3     <= '0;
            o_res_wgt_sum <= '0;
            o_res_pos     <= 1'b0;
            o_pos_cnt     <= '0;
        end else begin
            ptr           <= start_ok ? '0 : (issue && !last_rd) ? ptr + 1'b1 : ptr;
            o_busy        <= run && run_nx;
            o_rd_en       <= issue;
            o_rd_addr     <= issue ? ptr : o_rd_addr;
            o_cls_im1     <= cls_vld ? i_rd_im1 : '0;
            o_cls_im2     <= cls_vld ? i_rd_im2 : '0;
            o_cls_im3     <= cls_vld ? i_rd_im3 : '0;
            o_res_wgt_sum <= res_vld ? i_cls_wgt_sum : '0;
            o_res_pos     <= res_vld && i_cls_pos;
            o_pos_cnt     <= start_ok ? '0 :
                             (o_res_we && o_res_pos && o_pos_cnt != (AW+1)'(N_PIX)) ? o_pos_cnt + 1'b1 :
                             o_pos_cnt;
        end
    end

    lin_class_dly #(.DEPTH(L), .W(AW)) u_dly (
        .clk     (i_clk),
        .rst     (i_rst),
        .flush   (flush),
        .in_vld  (o_rd_en),
        .in_addr (o_rd_addr),
        .vld     (vld),
        .out_addr(o_res_addr)
    );

    assign o_res_we = vld[L-1];
endmodule

// File: tb/tb_lin_class_seq.sv
// tb_lin_class_seq: directed checks of lin_class_seq against image RAM and lin_class models
module tb_lin_class_seq;
    import lin_class_pkg::*;

    logic          clk, rst, i_start, i_pause, i_abort;
    logic          o_busy, o_done, o_rd_en, o_res_we, o_res_pos;
    logic [AW-1:0] o_rd_addr, o_res_addr;
    logic [DW-1:0] rd_im1, rd_im2, rd_im3, o_cls_im1, o_cls_im2, o_cls_im3;
    logic [SW-1:0] cls_sum, o_res_wgt_sum;
    logic          cls_pos;
    logic [AW:0]   o_pos_cnt;
    logic [SW-1:0] cls_s [4];
    logic          cls_p [4];
    int compared = 0;
    int mismatched = 0;
    int gcnt = 0;

    lin_class_seq dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_pause(i_pause), .i_abort(i_abort),
        .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_im1(rd_im1), .i_rd_im2(rd_im2), .i_rd_im3(rd_im3),
        .o_cls_im1(o_cls_im1), .o_cls_im2(o_cls_im2), .o_cls_im3(o_cls_im3),
        .i_cls_wgt_sum(cls_sum), .i_cls_pos(cls_pos),
        .o_res_we(o_res_we), .o_res_addr(o_res_addr), .o_res_wgt_sum(o_res_wgt_sum),
        .o_res_pos(o_res_pos), .o_pos_cnt(o_pos_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int pix(input int a, input int ch);
        logic [11:0] t;
        t = ch == 1 ? 12'(a) : ch == 2 ? 12'(a >> 6) : 12'(a * 37 + 11);
        return int'(t[5:0]);
    endfunction

    function automatic int wmodel(input int i1, input int i2, input int i3);
        return 3 * i1 + 2 * i2 - 4 * i3 - 60;
    endfunction

    function automatic int gold(input int a);
        return wmodel(pix(a, 1), pix(a, 2), pix(a, 3));
    endfunction

    // image RAMs with one cycle of read latency
    always @(posedge clk) begin
        if (o_rd_en) begin
            rd_im1 <= 6'(pix(int'(o_rd_addr), 1));
            rd_im2 <= 6'(pix(int'(o_rd_addr), 2));
            rd_im3 <= 6'(pix(int'(o_rd_addr), 3));
        end
    end

    // lin_class: four-stage free-running pipeline
    always @(posedge clk) begin : cls_model
        int v;
        v = wmodel(int'(o_cls_im1), int'(o_cls_im2), int'(o_cls_im3));
        cls_s[0] <= 16'(v);
        cls_p[0] <= v > 0;
        for (int i = 1; i < 4; i++) begin
            cls_s[i] <= cls_s[i-1];
            cls_p[i] <= cls_p[i-1];
        end
    end
    assign cls_sum = cls_s[3];
    assign cls_pos = cls_p[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; i_start = 0; i_pause = 0; i_abort = 0;
        tick(); tick();
        compared++;
        if ({o_busy, o_done, o_rd_en, o_res_we, o_res_pos} !== 5'b0) begin
            mismatched++; $display("FAIL reset_flags got %b exp 00000", {o_busy, o_done, o_rd_en, o_res_we, o_res_pos});
        end
        compared++;
        if (o_rd_addr !== '0 || o_res_addr !== '0) begin
            mismatched++; $display("FAIL reset_addr got rd=%0d res=%0d exp 0", o_rd_addr, o_res_addr);
        end
        compared++;
        if (o_pos_cnt !== '0) begin
            mismatched++; $display("FAIL reset_pos_cnt got %0d exp 0", o_pos_cnt);
        end
        compared++;
        if ({o_cls_im1, o_cls_im2, o_cls_im3} !== '0 || o_res_wgt_sum !== '0) begin
            mismatched++; $display("FAIL reset_data got cls=%h sum=%h exp 0", {o_cls_im1, o_cls_im2, o_cls_im3}, o_res_wgt_sum);
        end
        rst = 0;
        tick(); tick();
        compared++;
        if (o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
            mismatched++; $display("FAIL idle_after_reset got busy=%b rd_en=%b exp 0 0", o_busy, o_rd_en);
        end
    endtask

    task automatic test_frame(input int p);
        int exp_rd, exp_wr, first_wr, last_rd, last_wr, done_at, done_cnt, pcnt;
        logic paused;
        exp_rd = 0; exp_wr = 0; first_wr = -1; last_rd = -1; last_wr = -1;
        done_at = -1; done_cnt = 0; pcnt = 0;
        i_start = 1; tick(); i_start = 0;
        for (int n = 1; n <= 4110 + p; n++) begin
            paused = i_pause;
            tick();
            if (o_rd_en) begin
                compared++;
                if (paused || o_rd_addr !== AW'(exp_rd)) begin
                    mismatched++; $display("FAIL rd_addr n=%0d got %0d exp %0d paused=%b", n, o_rd_addr, exp_rd, paused);
                end
                exp_rd++; last_rd = n;
            end
            if (o_res_we) begin
                compared++;
                if (o_res_addr !== AW'(exp_wr) || o_res_wgt_sum !== 16'(gold(exp_wr)) || o_res_pos !== (gold(exp_wr) > 0)) begin
                    mismatched++;
                    $display("FAIL res_write n=%0d got addr=%0d sum=%h pos=%b exp addr=%0d sum=%h pos=%b",
                             n, o_res_addr, o_res_wgt_sum, o_res_pos, exp_wr, 16'(gold(exp_wr)), gold(exp_wr) > 0);
                end
                if (first_wr < 0) first_wr = n;
                last_wr = n; exp_wr++;
            end
            compared++;
            if (o_busy !== (n <= 4103 + p)) begin
                mismatched++; $display("FAIL busy n=%0d got %b exp %b", n, o_busy, n <= 4103 + p);
            end
            if (o_done) begin
                done_cnt++; done_at = n;
            end
            if (p > 0 && pcnt == 0 && !i_pause && o_rd_en && o_rd_addr == AW'(99)) begin
                i_pause = 1; pcnt = p;
            end else if (i_pause) begin
                pcnt--;
                if (pcnt == 0) i_pause = 0;
            end
        end
        i_pause = 0;
        compared++;
        if (exp_rd != 4096 || exp_wr != 4096) begin
            mismatched++; $display("FAIL frame_counts got rd=%0d wr=%0d exp 4096 4096", exp_rd, exp_wr);
        end
        compared++;
        if (first_wr != 8 || last_rd != 4096 + p || last_wr != 4103 + p) begin
            mismatched++; $display("FAIL frame_timing got first_wr=%0d last_rd=%0d last_wr=%0d exp 8 %0d %0d",
                                   first_wr, last_rd, last_wr, 4096 + p, 4103 + p);
        end
        compared++;
        if (last_wr - first_wr + 1 - 4096 != p) begin
            mismatched++; $display("FAIL write_gap got %0d exp %0d", last_wr - first_wr + 1 - 4096, p);
        end
        compared++;
        if (done_cnt != 1 || done_at != 4104 + p) begin
            mismatched++; $display("FAIL done got count=%0d at=%0d exp 1 at %0d", done_cnt, done_at, 4104 + p);
        end
        compared++;
        if (o_pos_cnt !== (AW+1)'(gcnt)) begin
            mismatched++; $display("FAIL pos_cnt got %0d exp %0d", o_pos_cnt, gcnt);
        end
    endtask

    task automatic test_abort();
        int bench_cnt, bad;
        logic hit;
        bench_cnt = 0; hit = 0; bad = 0;
        i_start = 1; tick(); i_start = 0;
        for (int n = 1; n <= 2100 && !hit; n++) begin
            tick();
            if (o_res_we && o_res_pos) bench_cnt++;
            if (o_rd_en && o_rd_addr == AW'(2000)) hit = 1;
        end
        compared++;
        if (!hit) begin
            mismatched++; $display("FAIL abort_reach got no read of 2000 exp read of 2000");
        end
        i_abort = 1; tick(); i_abort = 0;
        compared++;
        if (o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_res_we !== 1'b0) begin
            mismatched++; $display("FAIL abort_idle got busy=%b rd_en=%b we=%b exp 0 0 0", o_busy, o_rd_en, o_res_we);
        end
        compared++;
        if (o_pos_cnt !== (AW+1)'(bench_cnt)) begin
            mismatched++; $display("FAIL abort_pos_cnt got %0d exp %0d", o_pos_cnt, bench_cnt);
        end
        for (int n = 0; n < 20; n++) begin
            tick();
            if (o_res_we || o_done || o_rd_en || o_pos_cnt != (AW+1)'(bench_cnt)) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++; $display("FAIL abort_quiet got %0d active cycles exp 0", bad);
        end
        i_start = 1; tick(); i_start = 0;
        compared++;
        if (o_pos_cnt !== '0) begin
            mismatched++; $display("FAIL restart_pos_clear got %0d exp 0", o_pos_cnt);
        end
        tick();
        compared++;
        if (o_rd_en !== 1'b1 || o_rd_addr !== '0) begin
            mismatched++; $display("FAIL restart_rd got en=%b addr=%0d exp 1 0", o_rd_en, o_rd_addr);
        end
        for (int n = 2; n <= 8; n++) tick();
        compared++;
        if (o_res_we !== 1'b1 || o_res_addr !== '0 || o_res_wgt_sum !== 16'(gold(0))) begin
            mismatched++; $display("FAIL restart_wr got we=%b addr=%0d sum=%h exp 1 0 %h", o_res_we, o_res_addr, o_res_wgt_sum, 16'(gold(0)));
        end
        i_abort = 1; tick(); i_abort = 0; tick();
    endtask

    task automatic test_start_ignored();
        int bad;
        bad = 0;
        i_start = 1; tick(); i_start = 0;
        for (int n = 1; n <= 60; n++) begin
            i_start = n == 30;
            tick();
            compared++;
            if (o_rd_en !== 1'b1 || o_rd_addr !== AW'(n - 1)) begin
                mismatched++; $display("FAIL start_in_issue n=%0d got en=%b addr=%0d exp 1 %0d", n, o_rd_en, o_rd_addr, n - 1);
            end
        end
        i_start = 0;
        i_abort = 1; tick(); i_abort = 0;
        i_start = 1; i_abort = 1; tick(); i_start = 0; i_abort = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (o_busy || o_rd_en || o_res_we || o_done) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++; $display("FAIL start_abort_idle got %0d active cycles exp 0", bad);
        end
    endtask

    task automatic test_reset_drain();
        int bad;
        bad = 0;
        i_start = 1; tick(); i_start = 0;
        for (int n = 1; n <= 4099; n++) tick();
        compared++;
        if (o_busy !== 1'b1 || o_rd_en !== 1'b0) begin
            mismatched++; $display("FAIL in_drain got busy=%b rd_en=%b exp 1 0", o_busy, o_rd_en);
        end
        #2 rst = 1;
        #1;
        compared++;
        if ({o_busy, o_done, o_rd_en, o_res_we, o_res_pos} !== 5'b0 || o_pos_cnt !== '0 ||
            o_res_addr !== '0 || o_rd_addr !== '0 || o_res_wgt_sum !== '0) begin
            mismatched++; $display("FAIL async_reset got flags=%b cnt=%0d res_addr=%0d rd_addr=%0d exp all 0",
                                   {o_busy, o_done, o_rd_en, o_res_we, o_res_pos}, o_pos_cnt, o_res_addr, o_rd_addr);
        end
        tick(); rst = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (o_done || o_busy || o_res_we) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++; $display("FAIL reset_no_done got %0d active cycles exp 0", bad);
        end
        test_frame(0);
    endtask

    initial begin
        for (int a = 0; a < N_PIX; a++) if (gold(a) > 0) gcnt++;
        test_reset();
        test_frame(0);
        test_frame(10);
        test_abort();
        test_start_ignored();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
